cfa_log_ctrl: RTL and testbench
===============================

CFA_LOG_CTRL -- requirements
Module: cfa_log_ctrl

Interface
REQ-001 Parameter LOG_BASE, default `LOG_BASE, meaning byte address of the first log word.
REQ-002 Parameter LOG_SIZE, default 16'd64, meaning log capacity in 16-bit words (power of two not required, >=2).
REQ-003 clk  in  1  system clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfa_en  in  1  logging enable; when 0 no new grant issues.
REQ-006 br_req  in  1  branch requester holds high with br_src/br_dst stable until granted.
REQ-007 br_src, br_dst  in  16 each  branch source/destination addresses.
REQ-008 ctr_req  in  1  loop-counter requester holds high with ctr_val stable until granted.
REQ-009 ctr_val  in  16  loop-counter word.
REQ-010 br_gnt, ctr_gnt  out  1 each  one-cycle grant pulses; the requester drops or renews its request next cycle.
REQ-011 log_wr_en  out  1  log memory write strobe.
REQ-012 log_wr_addr  out  16  byte address of the word written.
REQ-013 log_wr_data  out  16  word written.
REQ-014 log_ptr  out  16  byte address of the next free word.
REQ-015 log_full  out  1  high while in FULL.
REQ-016 attest_req  out  1  request to the TCB to attest and drain the log.
REQ-017 attest_ack  in  1  TCB done; log may be reused.

Function
REQ-018 The FSM SHALL have states IDLE, BR2 and FULL; free = LOG_SIZE - count, where count is a register in the range 0..LOG_SIZE.
REQ-019 Selection in IDLE with cfa_en=1: a single requester is selected; when both request, select the one not granted most recently (last_gnt bit, reset value = counter, so branch wins first).
REQ-020 Branch selected with free>=2: in the same cycle, br_gnt=1 and log_wr of br_src at log_ptr; br_dst is latched; next state BR2; count+=1; log_ptr+=2.
REQ-021 In BR2: write latched dst at log_ptr; count+=1; log_ptr+=2; return to IDLE; no grant is issued in BR2.
REQ-022 Counter selected with free>=1: in the same cycle, ctr_gnt=1 and write ctr_val at log_ptr; count+=1; log_ptr+=2; remain IDLE.
REQ-023 If the selected request does not fit, the controller SHALL issue no grant or write, set attest_req=1 (registered) and go to FULL; an unselected request that would fit SHALL NOT be granted that cycle.
REQ-024 In FULL: log_full=1 and attest_req stays high; all requests are ignored; on attest_ack, count<=0, log_ptr<=LOG_BASE, attest_req<=0 and next state IDLE.
REQ-025 attest_ack outside FULL SHALL be ignored.
REQ-026 log_wr_* and grants are combinational from registered state plus inputs; log_wr_addr/log_wr_data are 0 when log_wr_en=0.
REQ-027 Address arithmetic is 16-bit; log_ptr never exceeds LOG_BASE+2*LOG_SIZE.
REQ-028 An exactly-full log with no pending request SHALL remain in IDLE, with entry to FULL only on a request that does not fit.
REQ-029 cfa_en=0 during BR2 SHALL still complete the dst write, because a branch entry is atomic.

Reset
REQ-030 On reset, the SHALL state be IDLE, count=0, log_ptr=LOG_BASE, attest_req=0, last_gnt=counter, and all strobes 0 in the following cycle.
REQ-031 Reset in BR2 SHALL discard the pending dst word.

Structure
REQ-032 State encodings, the word size constant (2 bytes) and the default LOG_SIZE SHALL reside in the shared cfa package/defines file alongside LOG_BASE.
REQ-033 The round-robin selector SHALL be one sub-module, cfa_rr_arb2; everything else stays flat.

Verification
REQ-034 Single branch (src=16'h E010, dst=16'h E200) at reset -> br_gnt cycle t writes E010 @LOG_BASE; t+1 writes E200 @LOG_BASE+2; log_ptr=LOG_BASE+4.
REQ-035 br_req and ctr_req held together -> grants alternate br, ctr, br, ctr ..., with no write gap other than BR2.
REQ-036 LOG_SIZE=4, three counters then a branch -> branch not granted; attest_req=1 next cycle; log_full=1; no write.
REQ-037 In FULL with requests held, then attest_ack pulse -> next cycle log_ptr=LOG_BASE, count=0; the pending branch is granted in the following IDLE cycle.
REQ-038 reset asserted during BR2 -> no dst write; log_ptr=LOG_BASE; state IDLE.
REQ-039 attest_ack in IDLE, cfa_en=0 with requests -> no state change and no grants.

Source files
------------

// File: rtl/cfa_log_ctrl_pkg.sv
// Shared constants and state encoding for the control-flow attestation log controller.
package cfa_log_ctrl_pkg;

  localparam logic [15:0] CFA_LOG_BASE   = 16'h0400;
  localparam logic [15:0] CFA_LOG_SIZE   = 16'd64;
  localparam logic [15:0] CFA_WORD_BYTES = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BR2  = 2'd1,
    ST_FULL = 2'd2
  } cfa_state_t;

endpackage

// File: rtl/cfa_rr_arb2.sv
// Two-way round-robin selector between the branch and loop-counter requesters.
module cfa_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic br_req,
  input  logic ctr_req,
  input  logic gnt_valid,
  input  logic gnt_br,
  output logic sel_br,
  output logic sel_ctr
);

  // Remembers which requester was granted last; starts as "counter" so branch wins first.
  logic last_br;

  assign sel_br  = br_req & (~ctr_req | ~last_br);
  assign sel_ctr = ctr_req & ~sel_br;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_br <= 1'b0;
    end else if (gnt_valid) begin
      last_br <= gnt_br;
    end
  end

endmodule

// File: rtl/cfa_log_ctrl.sv
// Log write controller: grants branch/counter requests and appends their words to the log memory.
module cfa_log_ctrl
  import cfa_log_ctrl_pkg::*;
#(
  parameter logic [15:0] LOG_BASE = CFA_LOG_BASE,
  parameter logic [15:0] LOG_SIZE = CFA_LOG_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfa_en,
  input  logic        br_req,
  input  logic [15:0] br_src,
  input  logic [15:0] br_dst,
  input  logic        ctr_req,
  input  logic [15:0] ctr_val,
  output logic        br_gnt,
  output logic        ctr_gnt,
  output logic        log_wr_en,
  output logic [15:0] log_wr_addr,
  output logic [15:0] log_wr_data,
  output logic [15:0] log_ptr,
  output logic        log_full,
  output logic        attest_req,
  input  logic        attest_ack,
  output cfa_state_t  dbg_state,
  output logic [15:0] dbg_count
);

  cfa_state_t  state, state_nxt;
  logic [15:0] count, count_nxt;
  logic [15:0] ptr_nxt;
  logic [15:0] dst_q, dst_nxt;
  logic        attest_q, attest_nxt;
  logic [15:0] free;
  logic        sel_br, sel_ctr;

  assign free       = LOG_SIZE - count;
  assign log_full   = (state == ST_FULL);
  assign attest_req = attest_q;
  assign dbg_state  = state;
  assign dbg_count  = count;

  cfa_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .br_req    (br_req),
    .ctr_req   (ctr_req),
    .gnt_valid (br_gnt | ctr_gnt),
    .gnt_br    (br_gnt),
    .sel_br    (sel_br),
    .sel_ctr   (sel_ctr)
  );

  // Strobes are qualified by reset so a reset landing in BR2 drops the pending dst word.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    ptr_nxt     = log_ptr;
    dst_nxt     = dst_q;
    attest_nxt  = attest_q;
    br_gnt      = 1'b0;
    ctr_gnt     = 1'b0;
    log_wr_en   = 1'b0;
    log_wr_addr = 16'd0;
    log_wr_data = 16'd0;
    case (state)
      ST_IDLE: begin
        if (cfa_en && !reset) begin
          if (sel_br) begin
            if (free >= 16'd2) begin
              br_gnt      = 1'b1;
              log_wr_en   = 1'b1;
              log_wr_addr = log_ptr;
              log_wr_data = br_src;
              dst_nxt     = br_dst;
              count_nxt   = count + 16'd1;
              ptr_nxt     = log_ptr + CFA_WORD_BYTES;
              state_nxt   = ST_BR2;
            end else begin
              attest_nxt = 1'b1;
              state_nxt  = ST_FULL;
            end
          end else if (sel_ctr) begin
            if (free >= 16'd1) begin
              ctr_gnt     = 1'b1;
              log_wr_en   = 1'b1;
              log_wr_addr = log_ptr;
              log_wr_data = ctr_val;
              count_nxt   = count + 16'd1;
              ptr_nxt     = log_ptr + CFA_WORD_BYTES;
            end else begin
              attest_nxt = 1'b1;
              state_nxt  = ST_FULL;
            end
          end
        end
      end
      ST_BR2: begin
        if (!reset) begin
          log_wr_en   = 1'b1;
          log_wr_addr = log_ptr;
          log_wr_data = dst_q;
        end
        count_nxt = count + 16'd1;
        ptr_nxt   = log_ptr + CFA_WORD_BYTES;
        state_nxt = ST_IDLE;
      end
      ST_FULL: begin
        if (attest_ack) begin
          count_nxt  = 16'd0;
          ptr_nxt    = LOG_BASE;
          attest_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= 16'd0;
      log_ptr  <= LOG_BASE;
      dst_q    <= 16'd0;
      attest_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      log_ptr  <= ptr_nxt;
      dst_q    <= dst_nxt;
      attest_q <= attest_nxt;
    end
  end

endmodule

// File: tb/tb_cfa_log_ctrl.sv
// Bench for cfa_log_ctrl: directed scenarios plus random traffic against a behavioural log model.
module tb_cfa_log_ctrl;
  import cfa_log_ctrl_pkg::*;

  localparam logic [15:0] BASE = 16'h0400;
  localparam int          SIZE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfa_en;
  logic        br_req;
  logic [15:0] br_src, br_dst;
  logic        ctr_req;
  logic [15:0] ctr_val;
  logic        br_gnt, ctr_gnt;
  logic        log_wr_en;
  logic [15:0] log_wr_addr, log_wr_data, log_ptr;
  logic        log_full, attest_req, attest_ack;
  cfa_state_t  dbg_state;
  logic [15:0] dbg_count;

  int n_total = 0;
  int n_bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  cfa_log_ctrl #(.LOG_BASE(BASE), .LOG_SIZE(16'(SIZE))) dut (
    .clk         (clk),
    .reset       (reset),
    .cfa_en      (cfa_en),
    .br_req      (br_req),
    .br_src      (br_src),
    .br_dst      (br_dst),
    .ctr_req     (ctr_req),
    .ctr_val     (ctr_val),
    .br_gnt      (br_gnt),
    .ctr_gnt     (ctr_gnt),
    .log_wr_en   (log_wr_en),
    .log_wr_addr (log_wr_addr),
    .log_wr_data (log_wr_data),
    .log_ptr     (log_ptr),
    .log_full    (log_full),
    .attest_req  (attest_req),
    .attest_ack  (attest_ack),
    .dbg_state   (dbg_state),
    .dbg_count   (dbg_count)
  );

  // behavioural model: words used, next free address, pending dst word, full/attest flags
  int          m_used;
  logic [15:0] m_ptr;
  bit          m_dst_pending;
  logic [15:0] m_dst;
  bit          m_full, m_attest;
  bit          m_last_was_br;

  // expected per-cycle outputs
  bit          e_bg, e_cg, e_we, e_go_full;
  logic [15:0] e_wa, e_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_used = 0;
    m_ptr = BASE;
    m_dst_pending = 0;
    m_dst = 16'd0;
    m_full = 0;
    m_attest = 0;
    m_last_was_br = 0;
  endtask

  task automatic compute_exp();
    bit pick_br;
    int need;
    e_bg = 0; e_cg = 0; e_we = 0; e_go_full = 0;
    e_wa = 16'd0; e_wd = 16'd0;
    if (!reset) begin
      if (m_dst_pending) begin
        e_we = 1; e_wa = m_ptr; e_wd = m_dst;
      end else if (!m_full && cfa_en && (br_req || ctr_req)) begin
        pick_br = br_req && (!ctr_req || !m_last_was_br);
        need = pick_br ? 2 : 1;
        if (SIZE - m_used >= need) begin
          e_we = 1; e_wa = m_ptr;
          if (pick_br) begin e_bg = 1; e_wd = br_src; end
          else begin e_cg = 1; e_wd = ctr_val; end
        end else begin
          e_go_full = 1;
        end
      end
    end
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_dst_pending) begin
      m_used++; m_ptr += 16'd2; m_dst_pending = 0;
    end else if (m_full) begin
      if (attest_ack) begin
        m_used = 0; m_ptr = BASE; m_full = 0; m_attest = 0;
      end
    end else if (e_bg) begin
      m_used++; m_ptr += 16'd2; m_dst_pending = 1; m_dst = br_dst; m_last_was_br = 1;
    end else if (e_cg) begin
      m_used++; m_ptr += 16'd2; m_last_was_br = 0;
    end else if (e_go_full) begin
      m_full = 1; m_attest = 1;
    end
  endtask

  // one clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    @(negedge clk);
    compute_exp();
    chk("br_gnt", br_gnt, e_bg);
    chk("ctr_gnt", ctr_gnt, e_cg);
    chk("wr_en", log_wr_en, e_we);
    chk("wr_addr", log_wr_addr, e_wa);
    chk("wr_data", log_wr_data, e_wd);
    chk("log_ptr", log_ptr, m_ptr);
    chk("log_full", log_full, m_full);
    chk("attest_req", attest_req, m_attest);
    chk("count", dbg_count, 32'(m_used));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; br_req = 0; ctr_req = 0; attest_ack = 0; cfa_en = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    reset = 1; cfa_en = 1; br_req = 0; ctr_req = 0; attest_ack = 0;
    br_src = 16'd0; br_dst = 16'd0; ctr_val = 16'd0;
    model_reset();
    cycle();
    cycle();
    reset = 0;

    // single branch from reset
    br_req = 1; br_src = 16'hE010; br_dst = 16'hE200;
    cycle();
    br_req = 0;
    cycle();
    chk("ptr_after_branch", log_ptr, BASE + 16'd4);

    // both requesters held: alternation, then the log fills
    do_reset();
    br_req = 1; br_src = 16'hB001; br_dst = 16'hB002;
    ctr_req = 1; ctr_val = 16'hC001;
    for (int i = 0; i < 5; i++) cycle();
    chk("full_after_alt", log_full, 1'b1);
    attest_ack = 1;
    cycle();
    attest_ack = 0;
    chk("ptr_after_ack", log_ptr, BASE);
    chk("count_after_ack", dbg_count, 16'd0);
    cycle();
    cycle();
    br_req = 0; ctr_req = 0;
    cycle();

    // three counters then a branch that does not fit
    do_reset();
    ctr_req = 1; ctr_val = 16'h0033;
    for (int i = 0; i < 3; i++) cycle();
    ctr_req = 0; br_req = 1; br_src = 16'hAAAA; br_dst = 16'hBBBB;
    cycle();
    chk("attest_on_overflow", attest_req, 1'b1);
    cycle();
    br_req = 0;
    attest_ack = 1;
    cycle();
    attest_ack = 0;

    // exactly full with no request stays out of FULL
    do_reset();
    ctr_req = 1; ctr_val = 16'h1234;
    for (int i = 0; i < 4; i++) cycle();
    ctr_req = 0;
    cycle();
    cycle();
    chk("exact_full_no_attest", attest_req, 1'b0);

    // reset during the dst cycle
    do_reset();
    br_req = 1; br_src = 16'h5555; br_dst = 16'h6666;
    cycle();
    br_req = 0; reset = 1;
    cycle();
    reset = 0;
    chk("ptr_after_br2_reset", log_ptr, BASE);
    cycle();

    // ack in IDLE and disabled logging are both inert
    attest_ack = 1; cfa_en = 0; br_req = 1; ctr_req = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("ptr_disabled", log_ptr, BASE);
    attest_ack = 0; cfa_en = 1; br_req = 0; ctr_req = 0;
    cycle();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bit was_bg, was_cg;
      cycle();
      was_bg = e_bg;
      was_cg = e_cg;
      if (was_bg || !br_req) begin
        br_req = ($urandom_range(0, 2) != 0);
        br_src = 16'($urandom);
        br_dst = 16'($urandom);
      end
      if (was_cg || !ctr_req) begin
        ctr_req = ($urandom_range(0, 2) != 0);
        ctr_val = 16'($urandom);
      end
      cfa_en     = ($urandom_range(0, 7) != 0);
      attest_ack = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
